// File: rtl/vec_pkg.sv
// Shared types and default widths for the minority-gate vector runner.
// The optional stop-on-first-error behaviour is selected in the runner with
// the macro MINORITY_VEC_RUNNER_STOP_ON_ERR_EN.
package vec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } vec_state_t;

    localparam int DEF_N_IN  = 3;
    localparam int DEF_N_OUT = 1;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_CW    = 16;

endpackage

// File: rtl/minority_vec_runner_if.sv
// Vector-memory write bus. The host (master) presents wr_addr/wr_data with a
// single-cycle wr_en strobe; there is no back-pressure, the runner (slave)
// simply drops strobes that arrive while a run is in progress.
interface minority_vec_runner_if #(
    parameter int AW = 5,
    parameter int W  = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vec_mem.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset so vectors survive a run abort.
module vec_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int W     = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/minority_vec_runner.sv
// Test-vector sequencer/checker for a combinational DUT (the minority gate).
// Each vector takes two cycles: APPLY registers the stimulus onto dut_in,
// CHECK compares the DUT response one full cycle later.
// Optional macro MINORITY_VEC_RUNNER_STOP_ON_ERR_EN: when defined, the first
// mismatch ends the run immediately (DONE) instead of running every vector.
module minority_vec_runner
    import vec_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = 5,
    parameter int CW    = DEF_CW
) (
    input  logic                 clk,
    input  logic                 reset,
    minority_vec_runner_if.slave wr,
    input  logic [AW:0]          num_vec,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic [N_OUT-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          vectornum,
    output logic [CW-1:0]        errors,
    output logic                 err_pulse,
    output logic [AW-1:0]        first_err_addr,
    output logic                 first_err_valid,
    output vec_state_t           state
);
    localparam int          W       = N_IN + N_OUT;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [AW-1:0]  addr;
    logic [AW:0]    num_lat;
    logic [AW:0]    num_clamped;
    logic [AW:0]    vec_next;
    logic [N_OUT-1:0] exp_q;
    logic [W-1:0]   rdata;
    logic           mismatch;
    logic           stop_now;
    logic           mem_we;

    assign busy        = (state == APPLY) || (state == CHECK);
    assign done        = (state == DONE);
    // Writes during a run would corrupt vectors still to be applied.
    assign mem_we      = wr.wr_en && !busy;
    // Requests beyond the memory size are clamped so addr never wraps.
    assign num_clamped = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
    assign vec_next    = vectornum + 1'b1;
    assign mismatch    = (dut_out != exp_q);

`ifdef MINORITY_VEC_RUNNER_STOP_ON_ERR_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    vec_mem #(.DEPTH(DEPTH), .AW(AW), .W(W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr.wr_addr),
        .wdata (wr.wr_data),
        .raddr (addr),
        .rdata (rdata)
    );

    // Run-control FSM with its registered datapath and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            dut_in          <= '0;
            vectornum       <= '0;
            errors          <= '0;
            err_pulse       <= 1'b0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
            addr            <= '0;
            num_lat         <= '0;
            exp_q           <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vectornum       <= '0;
                        errors          <= '0;
                        first_err_addr  <= '0;
                        first_err_valid <= 1'b0;
                        addr            <= '0;
                        num_lat         <= num_clamped;
                        state           <= (num_clamped == '0) ? DONE : APPLY;
                    end
                end
                APPLY: begin
                    dut_in <= rdata[W-1:N_OUT];
                    exp_q  <= rdata[N_OUT-1:0];
                    state  <= CHECK;
                end
                CHECK: begin
                    vectornum <= vec_next;
                    if (mismatch) begin
                        err_pulse <= 1'b1;
                        if (errors != '1) begin
                            errors <= errors + 1'b1;
                        end
                        if (!first_err_valid) begin
                            first_err_addr  <= addr;
                            first_err_valid <= 1'b1;
                        end
                    end
                    if ((vec_next == num_lat) || stop_now) begin
                        state <= DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
